// File: rtl/mips32_muldiv_pkg.sv
// Shared types for the MIPS32 HI/LO multiply/divide sequencer.
// MADD/MADDU codes only execute when MIPS32_MULDIV_MADD_EN is defined.
package mips32_muldiv_pkg;

  localparam int N_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } state_e;

endpackage

// File: rtl/mips32_muldiv_if.sv
// Issue-side request port, flush, completion and HI/LO view of the sequencer.
interface mips32_muldiv_if
  import mips32_muldiv_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic         req_val;
  logic         req_rdy;
  op_e          req_op;
  logic [N-1:0] req_rs;
  logic [N-1:0] req_rt;
  logic         kill;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         rsp_val;
  logic [N-1:0] rsp_dat;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output req_val, req_op, req_rs, req_rt, kill,
    input  req_rdy, busy, done, div_by_zero, rsp_val, rsp_dat, hi, lo
  );

  modport slave (
    input  req_val, req_op, req_rs, req_rt, kill,
    output req_rdy, busy, done, div_by_zero, rsp_val, rsp_dat, hi, lo
  );
endinterface

// File: rtl/mips32_muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
module mips32_muldiv_step #(
  parameter int N = 32
) (
  input  logic           is_div,
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   opnd,
  output logic [2*N-1:0] acc_next,
  output logic           q_bit
);
  logic [N:0] add_sum;
  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    add_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = {acc[2*N-1:N], acc[N-1]};
    diff     = shifted - {1'b0, opnd};
    q_bit    = 1'b0;
    acc_next = {add_sum, acc[N-1:1]};
    if (is_div) begin
      // No borrow out of the trial subtraction means the quotient bit is 1.
      q_bit    = ~diff[N];
      acc_next = {(q_bit ? diff[N-1:0] : shifted[N-1:0]), acc[N-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mips32_muldiv_ctrl.sv
// HI/LO owner and bit-serial MULT/DIV sequencer (IDLE -> CALC x N -> FIXUP).
// Define MIPS32_MULDIV_MADD_EN to execute MADD/MADDU as accumulate into {HI,LO}.
module mips32_muldiv_ctrl
  import mips32_muldiv_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N) + 1
) (
  input logic            clk,
  input logic            rst,
  mips32_muldiv_if.slave bus
);
  state_e         state_q, state_d;
  logic [N-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, rsp_dat_q, rsp_dat_d;
  logic [2*N-1:0] acc_q, acc_d, step_acc;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic           dbz_q, dbz_d, done_q, done_d, dbz_pulse_q, dbz_pulse_d;
  logic           rsp_val_q, rsp_val_d;
  logic           accept, mul_op, div_op, signed_op, rs_neg, rt_neg, q_bit;
  logic [N-1:0]   rs_mag, rt_mag, quot_s, rem_s;
  logic [2*N-1:0] prod_s;
`ifdef MIPS32_MULDIV_MADD_EN
  logic           madd_op, madd_q, madd_d;
`endif

  assign bus.req_rdy     = (state_q == ST_IDLE) && !bus.kill;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_pulse_q;
  assign bus.rsp_val     = rsp_val_q;
  assign bus.rsp_dat     = rsp_dat_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign accept          = bus.req_val && bus.req_rdy;

  mips32_muldiv_step #(.N(N)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  always_comb begin
    mul_op    = 1'b0;
    div_op    = 1'b0;
    signed_op = 1'b0;
`ifdef MIPS32_MULDIV_MADD_EN
    madd_op   = 1'b0;
`endif
    case (bus.req_op)
      OP_MULT:  begin mul_op = 1'b1; signed_op = 1'b1; end
      OP_MULTU: mul_op = 1'b1;
      OP_DIV:   begin div_op = 1'b1; signed_op = 1'b1; end
      OP_DIVU:  div_op = 1'b1;
`ifdef MIPS32_MULDIV_MADD_EN
      OP_MADD:  begin mul_op = 1'b1; signed_op = 1'b1; madd_op = 1'b1; end
      OP_MADDU: begin mul_op = 1'b1; madd_op = 1'b1; end
`endif
      default:  ;
    endcase
    rs_neg = signed_op && bus.req_rs[N-1];
    rt_neg = signed_op && bus.req_rt[N-1];
    rs_mag = rs_neg ? -bus.req_rs : bus.req_rs;
    rt_mag = rt_neg ? -bus.req_rt : bus.req_rt;
    prod_s = neg_res_q ? -acc_q : acc_q;
    quot_s = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    rem_s  = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    rsp_dat_d   = rsp_dat_q;
    done_d      = 1'b0;
    dbz_pulse_d = 1'b0;
    rsp_val_d   = 1'b0;
`ifdef MIPS32_MULDIV_MADD_EN
    madd_d      = madd_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept && (mul_op || div_op)) begin
          state_d   = ST_CALC;
          cnt_d     = CW'(N);
          is_div_d  = div_op;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          dbz_d     = div_op && (bus.req_rt == '0);
          acc_d     = {{N{1'b0}}, (div_op ? rs_mag : rt_mag)};
          opnd_d    = div_op ? rt_mag : rs_mag;
`ifdef MIPS32_MULDIV_MADD_EN
          madd_d    = madd_op;
`endif
        end else if (accept) begin
          case (bus.req_op)
            OP_MTHI: hi_d = bus.req_rs;
            OP_MTLO: lo_d = bus.req_rs;
            OP_MFHI: begin rsp_val_d = 1'b1; rsp_dat_d = hi_q; end
            OP_MFLO: begin rsp_val_d = 1'b1; rsp_dat_d = lo_q; end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (bus.kill) begin
          state_d = ST_IDLE;
        end else begin
          // The quotient bit drops into the LSB vacated by the shift.
          acc_d = {step_acc[2*N-1:1], step_acc[0] | q_bit};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        state_d = ST_IDLE;
        if (!bus.kill) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d        = rem_s;
            lo_d        = dbz_q ? {N{1'b1}} : quot_s;
            dbz_pulse_d = dbz_q;
          end else begin
`ifdef MIPS32_MULDIV_MADD_EN
            {hi_d, lo_d} = madd_q ? ({hi_q, lo_q} + prod_s) : prod_s;
`else
            {hi_d, lo_d} = prod_s;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      rsp_dat_q   <= '0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
      rsp_val_q   <= 1'b0;
`ifdef MIPS32_MULDIV_MADD_EN
      madd_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      rsp_dat_q   <= rsp_dat_d;
      done_q      <= done_d;
      dbz_pulse_q <= dbz_pulse_d;
      rsp_val_q   <= rsp_val_d;
`ifdef MIPS32_MULDIV_MADD_EN
      madd_q      <= madd_d;
`endif
    end
  end
endmodule

// File: doc/mips32_muldiv_ctrl.md
Name: mips32_muldiv_ctrl

Overview:
Multi-cycle sequencer for the MIPS32 HI/LO special-purpose registers. It owns the architectural HI and LO and executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle. It also executes MTHI/MTLO/MFHI/MFLO and presents HI/LO to the ALU stage. It sits beside the ALU and is fed by the decode/issue stage through a valid/ready request port.

Parameters:
N, 32, datapath width in bits; operands are N bits, HI and LO are N bits each.
CW, $clog2(N)+1, iteration counter width.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-high
req_val  in  1  request valid
req_rdy  out  1  request accepted at this edge when req_val=1; combinational: (state==IDLE) && !kill
req_op  in  4  operation code (package enum)
req_rs  in  N  operand rs (dividend/multiplicand/MT source)
req_rt  in  N  operand rt (divisor/multiplier)
kill  in  1  abort in-flight mul/div (exception flush)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: mul/div result written to HI/LO
div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU divisor was 0
rsp_val  out  1  MFHI/MFLO read data valid (one-cycle pulse)
rsp_dat  out  N  MFHI/MFLO read data
hi  out  N  architectural HI
lo  out  N  architectural LO

Behaviour:
- Reset (async, rst=1): state=IDLE, hi=0, lo=0, done=0, div_by_zero=0, rsp_val=0, rsp_dat=0, counter=0. busy=0 and req_rdy=!kill follow combinationally.
- Ops: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MFHI=6, MFLO=7, MADD=8, MADDU=9. Codes 10-15 are accepted as NOP: no state change, no pulses.
- States: IDLE, CALC, FIXUP.
- Accept edge E0 (req_val && req_rdy), mul/div: latch operand magnitudes. Signed ops take the two's-complement absolute value. Record result signs. Counter=N. Go to CALC.
- CALC: edges E1..EN perform one iteration each. Multiply is shift-add into a 2N-bit accumulator. Divide is restoring, 1 quotient bit per edge. Counter decrements. At counter==1 go to FIXUP.
- FIXUP, edge EN+1:
  - Apply sign correction. Product is negated if operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Write {hi,lo}: product gives hi=upper N bits, lo=lower N bits; divide gives hi=remainder, lo=quotient.
  - done=1 for the cycle after EN+1. State returns to IDLE, so req_rdy=1 in that same cycle and back-to-back issue is allowed.
- Total latency: done visible N+1 edges after the accept edge (33 for N=32).
- Divide by zero: iterations still run, so latency is unchanged. Result is hi=req_rs, lo={N{1}}, and div_by_zero pulses with done.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no flag.
- MTHI/MTLO: accepted only in IDLE. hi/lo is written at the accept edge. No done pulse, no busy.
- MFHI/MFLO: accepted only in IDLE. rsp_dat = hi/lo as held before the accept edge. rsp_val=1 for the following cycle.
- Reads during a mul/div are stalled by req_rdy=0; stale HI/LO is never returned.
- kill=1 in CALC or FIXUP: at the next edge go to IDLE. hi/lo are unchanged, and done and div_by_zero stay 0. kill in IDLE has no effect on state, but blocks acceptance that cycle.
- rst asserted mid-operation: immediate return to IDLE; hi/lo are cleared.
- hi and lo change only at: reset, MTHI/MTLO accept, FIXUP.

Optional Feature:
Macro MIPS32_MULDIV_MADD_EN.
- Defined: MADD (8) and MADDU (9) sequence like MULT/MULTU. In FIXUP, {hi,lo} <= {hi,lo} + signed/unsigned product, with a 2N-bit add that wraps modulo 2^(2N). done pulses as for MULT.
- Undefined: codes 8/9 are NOP like codes 10-15, and no accumulate adder is synthesized.

Decomposition:
- Package mips32_muldiv_pkg: op enum (4-bit), state enum (IDLE/CALC/FIXUP), N default constant.
- One natural sub-module, mips32_muldiv_step: the combinational single-iteration datapath. Inputs are mode (mul/div), partial accumulator/remainder, and operand. It outputs the next accumulator/remainder and the quotient bit. The controller holds all registers, the counter and the FSM.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done on the 33rd edge after accept; hi=0xFFFFFFFE, lo=0x00000001; busy=1 throughout; req_rdy=0 until done.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x1234 rt=0 -> latency 33; hi=0x1234, lo=0xFFFFFFFF; div_by_zero pulses with done.
- MTHI 0xA5A5A5A5 then MFHI on the next cycle -> rsp_val=1 one cycle after MFHI accept, rsp_dat=0xA5A5A5A5. MFHI issued during MULT -> held off (req_rdy=0) until done, then returns the new hi.
- MULT started, kill at the 10th CALC edge -> IDLE next edge; hi/lo keep prior values; no done. rst mid-CALC -> hi=lo=0, busy=0 immediately.
- With MIPS32_MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Without the macro: same stimulus leaves hi/lo unchanged and no done pulse.
